// File: rtl/jk_counter_ctrl.sv
// jk_counter_ctrl: drives J/K of WIDTH external JK flip-flops as a loadable
// up/down counter that stops at a latched terminal value and pulses tc.
module jk_counter_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_dir,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             tc
);
    typedef enum logic [2:0] {IDLE, RUN, LOAD, CLEAR, DONE} state_t;
    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_STOP  = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    state_t           state, state_n;
    logic [WIDTH-1:0] term_r, ld_r, tog;
    logic             dir_r, accept, at_term;

    assign cmd_ready = (state == IDLE) || (state == RUN);
    assign accept    = cmd_valid && cmd_ready;
    assign at_term   = q_fb == term_r;
    assign busy      = state != IDLE;
    assign tc        = state == DONE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            term_r <= '0;
            dir_r  <= 1'b0;
            ld_r   <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && accept && cmd_op == OP_START) begin
                term_r <= cmd_data;
                dir_r  <= cmd_dir;
            end
            if (state == IDLE && accept && cmd_op == OP_LOAD)
                ld_r <= cmd_data;
        end
    end

    // Bit i toggles when all lower bits are 1 (up) or all 0 (down)
    always_comb begin
        logic c;
        c = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            tog[i] = c;
            c      = c & (dir_r ? ~q_fb[i] : q_fb[i]);
        end
    end

    always_comb begin
        state_n = state;
        j       = '0;
        k       = '0;
        case (state)
            IDLE:
                if (accept)
                    state_n = cmd_op == OP_START ? RUN :
                              cmd_op == OP_LOAD  ? LOAD :
                              cmd_op == OP_CLEAR ? CLEAR : IDLE;
            RUN:
                if (accept && cmd_op == OP_STOP)
                    state_n = IDLE;
                else if (at_term)
                    state_n = DONE;
                else begin
                    j = tog;
                    k = tog;
                end
            LOAD: begin
                j       = ld_r;
                k       = ~ld_r;
                state_n = IDLE;
            end
            CLEAR: begin
                k       = '1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
